// File: rtl/teclado_escaner_if.sv
// Keypad scanner bus: matrix pins on one side, key events on the other.
// TECLA_ATASCADA exists only when TECLADO_ATASCO_EN is defined.
interface teclado_escaner_if;
  logic [3:0] FILAS;
  logic [3:0] COLUMNAS;
  logic [3:0] DIGITO;
  logic       DIGITO_STB;
  logic       SOLICITUD_ACCESO;
`ifdef TECLADO_ATASCO_EN
  logic       TECLA_ATASCADA;
`endif

  modport master (
    input  FILAS,
    output COLUMNAS,
    output DIGITO,
    output DIGITO_STB,
`ifdef TECLADO_ATASCO_EN
    output TECLA_ATASCADA,
`endif
    output SOLICITUD_ACCESO
  );

  modport slave (
    output FILAS,
    input  COLUMNAS,
    input  DIGITO,
    input  DIGITO_STB,
`ifdef TECLADO_ATASCO_EN
    input  TECLA_ATASCADA,
`endif
    input  SOLICITUD_ACCESO
  );
endinterface

// File: rtl/teclado_escaner.sv
// 4x4 keypad scanner: sync, debounce, one strobe per press.
// Optional stuck-key detection with TECLADO_ATASCO_EN.
module teclado_escaner #(
  parameter int SCAN_CYCLES     = 4,
`ifdef TECLADO_ATASCO_EN
  parameter int ATASCO_CYCLES   = 1000,
`endif
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RESET,
  teclado_escaner_if.master bus
);

  localparam int SW = $clog2(SCAN_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ESCANEO,
    REBOTE,
    EMITIR,
    ESPERA_SOLTAR
  } estado_t;

  estado_t state, state_d;

  logic [3:0]    fs_q1, fs;
  logic [1:0]    col, col_d;
  logic [SW-1:0] scan_cnt, scan_d;
  logic [DW-1:0] deb_cnt, deb_d;
  logic [3:0]    fila, fila_d;
  logic [3:0]    digito, digito_d;
  logic          stb, stb_d;
  logic          sol, sol_d;

  logic [1:0] r;
  logic       fs_onehot;
  logic       es_digito;
  logic       es_asterisco;
  logic [3:0] codigo;
  logic       deb_fin;

  assign fs_onehot = (fs != 4'd0) && ((fs & (fs - 4'd1)) == 4'd0);
  assign deb_fin   = deb_cnt >= DW'(DEBOUNCE_CYCLES - 1);

  always_comb begin
    r = 2'd0;
    unique case (1'b1)
      fila[0]: r = 2'd0;
      fila[1]: r = 2'd1;
      fila[2]: r = 2'd2;
      fila[3]: r = 2'd3;
      default: r = 2'd0;
    endcase
  end

  // Row 3 is "* 0 # D": only column 1 is a digit there.
  always_comb begin
    es_asterisco = (r == 2'd3) && (col == 2'd0);
    es_digito    = ((r != 2'd3) && (col != 2'd3))
                || ((r == 2'd3) && (col == 2'd1));
    if (r == 2'd3)
      codigo = 4'd0;
    else
      codigo = ({2'b00, r} * 4'd3) + {2'b00, col} + 4'd1;
  end

`ifdef TECLADO_ATASCO_EN
  localparam int AW = $clog2(ATASCO_CYCLES + 2);
  logic [AW-1:0] atasco_cnt, atasco_d;
  logic          atascada, atascada_d;
`endif

  always_comb begin
    state_d  = state;
    col_d    = col;
    scan_d   = scan_cnt;
    deb_d    = deb_cnt;
    fila_d   = fila;
    digito_d = digito;
    stb_d    = 1'b0;
    sol_d    = 1'b0;
    unique case (state)
      ESCANEO: begin
        if (scan_cnt == SW'(SCAN_CYCLES - 1)) begin
          scan_d = '0;
          if (fs_onehot) begin
            fila_d  = fs;
            deb_d   = DW'(1);
            state_d = REBOTE;
          end else begin
            col_d = col + 2'd1;
          end
        end else begin
          scan_d = scan_cnt + SW'(1);
        end
      end
      REBOTE: begin
        if (fs != fila) begin
          col_d   = col + 2'd1;
          scan_d  = '0;
          deb_d   = '0;
          state_d = ESCANEO;
        end else if (deb_fin) begin
          deb_d   = '0;
          state_d = EMITIR;
          if (es_digito) begin
            digito_d = codigo;
            stb_d    = 1'b1;
          end else if (es_asterisco) begin
            sol_d = 1'b1;
          end
        end else begin
          deb_d = deb_cnt + DW'(1);
        end
      end
      EMITIR: begin
        deb_d   = '0;
        state_d = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (fs != 4'd0) begin
          deb_d = '0;
        end else if (deb_fin) begin
          deb_d   = '0;
          col_d   = col + 2'd1;
          scan_d  = '0;
          state_d = ESCANEO;
        end else begin
          deb_d = deb_cnt + DW'(1);
        end
      end
      default: state_d = ESCANEO;
    endcase
  end

`ifdef TECLADO_ATASCO_EN
  always_comb begin
    atasco_d = '0;
    if (state == ESPERA_SOLTAR && state_d == ESPERA_SOLTAR) begin
      if (atasco_cnt == AW'(ATASCO_CYCLES + 1))
        atasco_d = atasco_cnt;
      else
        atasco_d = atasco_cnt + AW'(1);
    end
    atascada_d = (state_d == ESPERA_SOLTAR)
              && (atasco_d > AW'(ATASCO_CYCLES));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      atasco_cnt <= '0;
      atascada   <= 1'b0;
    end else begin
      atasco_cnt <= atasco_d;
      atascada   <= atascada_d;
    end
  end

  assign bus.TECLA_ATASCADA = atascada;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fs_q1    <= 4'd0;
      fs       <= 4'd0;
      state    <= ESCANEO;
      col      <= 2'd0;
      scan_cnt <= '0;
      deb_cnt  <= '0;
      fila     <= 4'd0;
      digito   <= 4'd0;
      stb      <= 1'b0;
      sol      <= 1'b0;
    end else begin
      fs_q1    <= bus.FILAS;
      fs       <= fs_q1;
      state    <= state_d;
      col      <= col_d;
      scan_cnt <= scan_d;
      deb_cnt  <= deb_d;
      fila     <= fila_d;
      digito   <= digito_d;
      stb      <= stb_d;
      sol      <= sol_d;
    end
  end

  assign bus.COLUMNAS         = 4'b0001 << col;
  assign bus.DIGITO           = digito;
  assign bus.DIGITO_STB       = stb;
  assign bus.SOLICITUD_ACCESO = sol;

endmodule
